bsg_cache_to_dram_ctrl_rx: RTL and testbench



---
 rtl/bsg_cache_to_dram_ctrl_rx_pkg.sv | 14 +
 rtl/bsg_cache_to_dram_ctrl_rx_credit.sv | 37 +++
 rtl/bsg_counter_clear_up.sv | 28 ++
 rtl/bsg_fifo_1r1w_small.sv | 61 ++++++
 rtl/bsg_cache_to_dram_ctrl_rx.sv | 105 ++++++++++
 tb/tb_bsg_cache_to_dram_ctrl_rx.sv | 312 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bsg_cache_to_dram_ctrl_rx_pkg.sv
// Shared sizing helpers for the cache-to-DRAM controller rx/tx blocks.
package bsg_cache_to_dram_ctrl_rx_pkg;

  // Tag width for a given number of caches; at least one bit so ports never collapse.
  function automatic int lg_num_cache(input int num_cache);
    return (num_cache <= 1) ? 1 : $clog2(num_cache);
  endfunction

  // Width needed to hold a credit value from 0 up to and including the buffer depth.
  function automatic int credit_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_cache_to_dram_ctrl_rx_credit.sv
// Credit counter guarding the rx data buffer, plus request-ready qualification.
module bsg_cache_to_dram_ctrl_rx_credit
  import bsg_cache_to_dram_ctrl_rx_pkg::*;
#(
  parameter int fifo_els_p            = 8,
  parameter int block_size_in_words_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic accept_i,
  input  logic handoff_i,
  input  logic tag_ready_i,
  output logic ready_o
);
  localparam int cw_lp = credit_width(fifo_els_p);
  localparam logic [cw_lp-1:0] block_lp = cw_lp'(block_size_in_words_p);
  localparam logic [cw_lp-1:0] full_lp  = cw_lp'(fifo_els_p);

  logic [cw_lp-1:0] credit_q, credit_d;

  // A request reserves a whole block of buffer space up front, so a beat can always be stored.
  assign ready_o = ~reset_i & tag_ready_i & (credit_q >= block_lp);

  // Reserve on accept, return one word per handoff; both may apply in one cycle.
  always_comb begin
    credit_d = credit_q;
    if (accept_i)  credit_d = credit_d - block_lp;
    if (handoff_i) credit_d = credit_d + 1'b1;
  end

  // Credit register.
  always_ff @(posedge clk_i) begin
    if (reset_i) credit_q <= full_lp;
    else         credit_q <= credit_d;
  end

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear has priority over up.
module bsg_counter_clear_up #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);
  logic [width_p-1:0] count_q, count_d;

  assign count_o = count_q;

  // Next count: clear wins, otherwise optionally increment.
  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (up_i) count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO; caller guarantees no enqueue when full and no dequeue when empty.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  assign ready_o = (count_q != full_cnt_lp);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];

  // Pointer advance wraps at the depth, not at the power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (v_i)    wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    if (yumi_i) rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    case ({v_i, yumi_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is written without reset; contents are only visible through v_o.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// Read-return path: buffers DRAM read beats and steers each block to the cache named by the head tag.
module bsg_cache_to_dram_ctrl_rx
  import bsg_cache_to_dram_ctrl_rx_pkg::*;
#(
  parameter int num_cache_p           = 1,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 4,
  parameter int fifo_els_p            = 8,
  parameter int tag_fifo_els_p        = 4,
  localparam int lg_num_cache_lp      = lg_num_cache(num_cache_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                v_i,
  input  logic [lg_num_cache_lp-1:0]          tag_i,
  output logic                                ready_o,
  input  logic                                app_rd_data_valid_i,
  input  logic [data_width_p-1:0]             app_rd_data_i,
  input  logic                                app_rd_data_end_i,
  output logic [num_cache_p*data_width_p-1:0] dma_data_o,
  output logic [num_cache_p-1:0]              dma_data_v_o,
  input  logic [num_cache_p-1:0]              dma_data_ready_i
);
  localparam int wc_w_lp = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam logic [wc_w_lp-1:0] last_word_lp = wc_w_lp'(block_size_in_words_p - 1);

  logic                       accept;
  logic                       handoff;
  logic                       last_word;
  logic                       tag_ready, tag_v;
  logic [lg_num_cache_lp-1:0] head_tag;
  logic                       data_ready, data_v;
  logic [data_width_p-1:0]    data_head;
  logic [wc_w_lp-1:0]         word_cnt;
  logic                       unused_end;

  // The burst-end marker carries no information the word counter does not already have.
  assign unused_end = app_rd_data_end_i;

  assign accept    = v_i & ready_o;
  assign last_word = (word_cnt == last_word_lp);
  assign handoff   = |(dma_data_v_o & dma_data_ready_i);

  bsg_fifo_1r1w_small #(
    .width_p(lg_num_cache_lp),
    .els_p  (tag_fifo_els_p)
  ) u_tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept),
    .ready_o(tag_ready),
    .data_i (tag_i),
    .v_o    (tag_v),
    .data_o (head_tag),
    .yumi_i (handoff & last_word)
  );

  // Credits keep this FIFO from filling; the ready gate only stops a violating beat from corrupting it.
  bsg_fifo_1r1w_small #(
    .width_p(data_width_p),
    .els_p  (fifo_els_p)
  ) u_data_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (app_rd_data_valid_i & data_ready),
    .ready_o(data_ready),
    .data_i (app_rd_data_i),
    .v_o    (data_v),
    .data_o (data_head),
    .yumi_i (handoff)
  );

  bsg_counter_clear_up #(
    .width_p(wc_w_lp)
  ) u_word_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(handoff & last_word),
    .up_i   (handoff & ~last_word),
    .count_o(word_cnt)
  );

  bsg_cache_to_dram_ctrl_rx_credit #(
    .fifo_els_p           (fifo_els_p),
    .block_size_in_words_p(block_size_in_words_p)
  ) u_credit (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .accept_i   (accept),
    .handoff_i  (handoff),
    .tag_ready_i(tag_ready),
    .ready_o    (ready_o)
  );

  assign dma_data_o = {num_cache_p{data_head}};

  // Only the cache named by the head tag sees a valid word.
  always_comb begin
    dma_data_v_o = '0;
    for (int k = 0; k < num_cache_p; k++) begin
      dma_data_v_o[k] = tag_v & data_v & (head_tag == lg_num_cache_lp'(k));
    end
  end

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
module tb_bsg_cache_to_dram_ctrl_rx;
  localparam int NC = 2;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            v_i;
  logic            tag_i;
  logic            ready_o;
  logic            app_rd_data_valid_i;
  logic [DW-1:0]   app_rd_data_i;
  logic            app_rd_data_end_i;
  logic [NC*DW-1:0] dma_data_o;
  logic [NC-1:0]   dma_data_v_o;
  logic [NC-1:0]   dma_data_ready_i;

  bsg_cache_to_dram_ctrl_rx #(
    .num_cache_p          (NC),
    .data_width_p         (DW),
    .block_size_in_words_p(BW),
    .fifo_els_p           (8),
    .tag_fifo_els_p       (4)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .v_i                (v_i),
    .tag_i              (tag_i),
    .ready_o            (ready_o),
    .app_rd_data_valid_i(app_rd_data_valid_i),
    .app_rd_data_i      (app_rd_data_i),
    .app_rd_data_end_i  (app_rd_data_end_i),
    .dma_data_o         (dma_data_o),
    .dma_data_v_o       (dma_data_v_o),
    .dma_data_ready_i   (dma_data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        tag;
    logic [1:0]  rdy;
    logic [31:0] base;
    logic [1:0]  exp_v;
    logic [3:0]  exp_credit;
  } fill_vec_t;

  sb_t       sb[$];
  int        pending_tags[$];
  int        beat_cnt = 0;
  int        tests = 0;
  int        fails = 0;
  fill_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic t);
    v_i   = 1'b1;
    tag_i = t;
    @(negedge clk_i);
    check("req_ready", {31'd0, ready_o}, 32'd1);
    if (ready_o) pending_tags.push_back(int'(t));
    tick();
    v_i = 1'b0;
  endtask

  // Queue the expected destination for a beat, then present it for one cycle.
  task automatic set_beat(input logic [31:0] d);
    sb_t e;
    app_rd_data_valid_i = 1'b1;
    app_rd_data_i       = d;
    app_rd_data_end_i   = (beat_cnt == BW - 1);
    e.port = (pending_tags.size() > 0) ? pending_tags[0] : -1;
    e.data = d;
    sb.push_back(e);
    beat_cnt++;
    if (beat_cnt == BW) begin
      beat_cnt = 0;
      if (pending_tags.size() > 0) void'(pending_tags.pop_front());
    end
  endtask

  task automatic end_beat();
    app_rd_data_valid_i = 1'b0;
    app_rd_data_end_i   = 1'b0;
  endtask

  task automatic drive_beats(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      set_beat(base + i);
      tick();
      end_beat();
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while (n < max_cycles && !(sb.size() == 0 && dma_data_v_o == '0)) begin
      tick();
      n++;
    end
    check({name, "_drained"}, sb.size(), 32'd0);
  endtask

  // Scoreboard: every handoff must match the oldest expected word and its destination port.
  always @(negedge clk_i) begin
    if (reset_i) begin
      sb.delete();
    end else begin
      if (dma_data_v_o == 2'b11) begin
        fails++;
        $display("FAIL onehot: dma_data_v_o=%b expected at most one bit", dma_data_v_o);
      end
      if (app_rd_data_valid_i && dut.u_data_fifo.count_q == 4'd8) begin
        fails++;
        $display("FAIL overflow: beat arrived with data buffer count %0d, required below 8",
                 dut.u_data_fifo.count_q);
      end
      for (int k = 0; k < NC; k++) begin
        if (dma_data_v_o[k] && dma_data_ready_i[k]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL handoff_unexpected: port %0d data 0x%0h, none expected", k,
                     dma_data_o[k*DW +: DW]);
          end else begin
            sb_t e;
            e = sb.pop_front();
            if (e.port != k || e.data !== dma_data_o[k*DW +: DW]) begin
              fails++;
              $display("FAIL handoff: port %0d data 0x%0h, required port %0d data 0x%0h", k,
                       dma_data_o[k*DW +: DW], e.port, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tag: 1'b1, rdy: 2'b10, base: 32'hA0,       exp_v: 2'b10, exp_credit: 4'd8};
    vecs[1] = '{tag: 1'b0, rdy: 2'b01, base: 32'h100,      exp_v: 2'b01, exp_credit: 4'd8};
    vecs[2] = '{tag: 1'b1, rdy: 2'b11, base: 32'h200,      exp_v: 2'b10, exp_credit: 4'd8};
    vecs[3] = '{tag: 1'b0, rdy: 2'b11, base: 32'hDEAD0000, exp_v: 2'b01, exp_credit: 4'd8};

    reset_i             = 1'b1;
    v_i                 = 1'b0;
    tag_i               = 1'b0;
    app_rd_data_valid_i = 1'b0;
    app_rd_data_i       = '0;
    app_rd_data_end_i   = 1'b0;
    dma_data_ready_i    = '0;
    tick();
    tick();
    @(negedge clk_i);
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_v", {30'd0, dma_data_v_o}, 32'd0);
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_ready", {31'd0, ready_o}, 32'd1);
    check("post_reset_credit", {28'd0, dut.u_credit.credit_q}, 32'd8);
    tick();

    // Single fills: table of tag / ready mask / data base.
    for (int i = 0; i < 4; i++) begin
      dma_data_ready_i = vecs[i].rdy;
      request(vecs[i].tag);
      check("fill_credit_reserved", {28'd0, dut.u_credit.credit_q}, 32'd4);
      set_beat(vecs[i].base);
      @(negedge clk_i);
      check("fill_no_bypass", {30'd0, dma_data_v_o}, 32'd0);
      tick();
      set_beat(vecs[i].base + 1);
      @(negedge clk_i);
      check("fill_first_valid", {30'd0, dma_data_v_o}, {30'd0, vecs[i].exp_v});
      tick();
      set_beat(vecs[i].base + 2);
      tick();
      set_beat(vecs[i].base + 3);
      tick();
      end_beat();
      wait_drain("fill", 20);
      check("fill_credit", {28'd0, dut.u_credit.credit_q}, {28'd0, vecs[i].exp_credit});
      check("fill_tag_popped", {29'd0, dut.u_tag_fifo.count_q}, 32'd0);
      @(negedge clk_i);
      check("fill_ready", {31'd0, ready_o}, 32'd1);
      tick();
    end

    // Credit limit.
    dma_data_ready_i = 2'b00;
    request(1'b0);
    request(1'b1);
    @(negedge clk_i);
    check("credit_zero", {28'd0, dut.u_credit.credit_q}, 32'd0);
    check("credit_zero_ready", {31'd0, ready_o}, 32'd0);
    tick();
    drive_beats(32'h300, 8);
    dma_data_ready_i = 2'b01;
    tick();
    dma_data_ready_i = 2'b00;
    @(negedge clk_i);
    check("credit_one", {28'd0, dut.u_credit.credit_q}, 32'd1);
    check("credit_one_ready", {31'd0, ready_o}, 32'd0);
    tick();
    dma_data_ready_i = 2'b01;
    tick();
    tick();
    tick();
    dma_data_ready_i = 2'b00;
    @(negedge clk_i);
    check("credit_four", {28'd0, dut.u_credit.credit_q}, 32'd4);
    check("credit_four_ready", {31'd0, ready_o}, 32'd1);
    tick();
    dma_data_ready_i = 2'b11;
    wait_drain("credit", 20);

    // Interleaved ownership: port check lives in the scoreboard.
    request(1'b0);
    request(1'b1);
    dma_data_ready_i = 2'b11;
    drive_beats(32'h400, 8);
    wait_drain("interleave", 20);

    // Backpressure for 10 cycles.
    dma_data_ready_i = 2'b00;
    request(1'b0);
    drive_beats(32'h500, 4);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk_i);
    check("bp_held", {28'd0, dut.u_data_fifo.count_q}, 32'd4);
    check("bp_v", {30'd0, dma_data_v_o}, 32'd1);
    tick();
    dma_data_ready_i = 2'b01;
    wait_drain("bp", 20);

    // Accept and handoff in the same cycle with credit at 4.
    dma_data_ready_i = 2'b00;
    request(1'b0);
    drive_beats(32'h600, 4);
    v_i              = 1'b1;
    tag_i            = 1'b1;
    dma_data_ready_i = 2'b01;
    @(negedge clk_i);
    check("simul_ready", {31'd0, ready_o}, 32'd1);
    check("simul_v", {30'd0, dma_data_v_o}, 32'd1);
    if (ready_o) pending_tags.push_back(1);
    tick();
    v_i = 1'b0;
    check("simul_credit", {28'd0, dut.u_credit.credit_q}, 32'd1);
    tick();
    tick();
    tick();
    check("simul_credit_back", {28'd0, dut.u_credit.credit_q}, 32'd4);
    dma_data_ready_i = 2'b11;
    drive_beats(32'h700, 4);
    wait_drain("simul", 20);
    check("simul_credit_full", {28'd0, dut.u_credit.credit_q}, 32'd8);

    // Reset after two of four handoffs.
    dma_data_ready_i = 2'b00;
    request(1'b1);
    drive_beats(32'h800, 4);
    dma_data_ready_i = 2'b10;
    tick();
    tick();
    reset_i          = 1'b1;
    dma_data_ready_i = 2'b00;
    pending_tags.delete();
    beat_cnt = 0;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_v", {30'd0, dma_data_v_o}, 32'd0);
    check("rst_mid_ready", {31'd0, ready_o}, 32'd1);
    check("rst_mid_credit", {28'd0, dut.u_credit.credit_q}, 32'd8);
    check("rst_mid_words", {30'd0, dut.u_word_cnt.count_q}, 32'd0);
    tick();
    dma_data_ready_i = 2'b01;
    request(1'b0);
    drive_beats(32'h900, 4);
    wait_drain("rst_fresh", 20);
    check("rst_fresh_credit", {28'd0, dut.u_credit.credit_q}, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
